// File: rtl/cr_xp10_decomp_fe_lfa_rd_ctl_pkg.sv
// ----------------------------------------------------------------------------
// cr_xp10_decompPKG
// Shared constants and types for the XP10 decompressor front-end LFA read path.
//   LFA_MEM_SZ          : depth of the lookahead FIFO
//   LFA_ADDR_W          : LFA address width (LFA_MEM_SZ == 2**LFA_ADDR_W)
//   lfa_rd_ctl_state_e  : read sequencer states
// ----------------------------------------------------------------------------
package cr_xp10_decompPKG;

   localparam int LFA_MEM_SZ = 1024;
   localparam int LFA_ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } lfa_rd_ctl_state_e;

endpackage

// File: rtl/cr_xp10_decomp_fe_lfa_rd_ctl_skid.sv
// ----------------------------------------------------------------------------
// cr_xp10_decomp_fe_lfa_skid
// Small synchronous FIFO that absorbs the LFA RAM read latency in front of the
// downstream parser.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail (ignored when full and not popping)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   clear      : discard every entry; wins over push and pop
//   occ        : number of valid entries
//   head_data  : oldest entry, forced to zero while empty
// ----------------------------------------------------------------------------
module cr_xp10_decomp_fe_lfa_skid
   import cr_xp10_decompPKG::*;
#(
   parameter int DATA_W = 70,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              clear,
   output logic [CNT_W-1:0]  occ,
   output logic [DATA_W-1:0] head_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [IDX_W-1:0]  wr_idx_r;
   logic [IDX_W-1:0]  rd_idx_r;
   logic [CNT_W-1:0]  occ_r;
   logic              pop_ok_s;
   logic              push_ok_s;

   // Index advance with wrap at DEPTH, which need not be a power of two.
   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(DEPTH - 1)) begin
         return {IDX_W{1'b0}};
      end else begin
         return idx + IDX_W'(1);
      end
   endfunction

   // A push into a full buffer is only accepted when the head leaves the same cycle.
   always_comb begin
      pop_ok_s  = pop && (occ_r != {CNT_W{1'b0}});
      push_ok_s = push && ((occ_r != CNT_W'(DEPTH)) || pop_ok_s);
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_idx_r <= {IDX_W{1'b0}};
         rd_idx_r <= {IDX_W{1'b0}};
         occ_r    <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_idx_r <= idx_inc(wr_idx_r);
         end
         if (pop_ok_s) begin
            rd_idx_r <= idx_inc(rd_idx_r);
         end
         occ_r <= occ_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
      end
   end

   // Entry storage; contents are qualified by occ_r so they need no reset.
   always_ff @(posedge clk) begin
      if (push_ok_s && !clear) begin
         mem_r[wr_idx_r] <= push_data;
      end
   end

   // Head presentation, zero while empty so the port reads 0 after reset or clear.
   always_comb begin
      if (occ_r != {CNT_W{1'b0}}) begin
         head_data = mem_r[rd_idx_r];
      end else begin
         head_data = {DATA_W{1'b0}};
      end
   end

   assign occ = occ_r;

endmodule

// File: rtl/cr_xp10_decomp_fe_lfa_rd_ctl.sv
// ----------------------------------------------------------------------------
// cr_xp10_decomp_fe_lfa_rd_ctl
// Read sequencer for the front-end lookahead FIFO. Issues speculative reads,
// lands the 1-cycle-latency read data in a skid buffer, hands entries to the
// parser over valid/ready, returns retired entries to the FIFO head and can
// rewind to the oldest unretired entry.
//   clk, rst          : clock, synchronous active-high reset
//   en                : permits new reads
//   lfa_rd_avail      : FIFO says lfa_raddr is inside [head, tail)
//   lfa_rd/lfa_raddr  : read strobe and address
//   lfa_rdata         : read data, one cycle after an accepted read
//   lfa_rd_ack/_addr  : head-advance pulse and new head address
//   out_valid/_data/_ready : parser handshake
//   retire            : release the oldest delivered, unretired entry
//   rewind            : drop speculation, replay from the oldest unretired entry
//   outstanding       : entries read but not yet retired
//   retire_err        : sticky, retire seen with nothing to retire
// ----------------------------------------------------------------------------
module cr_xp10_decomp_fe_lfa_rd_ctl
   import cr_xp10_decompPKG::*;
#(
   parameter int ADDR_W     = LFA_ADDR_W,
   parameter int MEM_SZ     = LFA_MEM_SZ,
   parameter int DATA_W     = 70,
   parameter int SKID_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              lfa_rd_avail,
   output logic              lfa_rd,
   output logic [ADDR_W-1:0] lfa_raddr,
   input  logic [DATA_W-1:0] lfa_rdata,
   output logic              lfa_rd_ack,
   output logic [ADDR_W-1:0] lfa_rd_ack_addr,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              retire,
   input  logic              rewind,
   output logic [ADDR_W:0]   outstanding,
   output logic              retire_err
);

   localparam int CNT_W = $clog2(SKID_DEPTH + 1);
   localparam int CR_W  = CNT_W + 1;

   lfa_rd_ctl_state_e state_r;
   // Pointers carry a page bit above the address so a full, fully-read FIFO
   // (rd == ret modulo MEM_SZ) is distinguishable from an empty one.
   logic [ADDR_W:0]   rd_ptr_r;
   logic [ADDR_W:0]   ret_ptr_r;
   logic [ADDR_W:0]   dlv_cnt_r;
   logic              inflight_r;
   logic              ack_r;
   logic [ADDR_W-1:0] ack_addr_r;
   logic              err_r;

   logic [CNT_W-1:0]  occ_s;
   logic [DATA_W-1:0] head_s;
   logic              pop_s;
   logic              rd_s;
   logic              push_s;
   logic              ret_ok_s;
   logic [ADDR_W:0]   ret_nxt_s;
   logic [CR_W-1:0]   used_s;
   logic [CR_W-1:0]   limit_s;

   // Issue, capture and retire decisions for the current cycle.
   always_comb begin
      pop_s     = (occ_s != {CNT_W{1'b0}}) && out_ready;
      // Credit check written as occ + inflight < DEPTH + pop to stay unsigned.
      used_s    = CR_W'(occ_s) + CR_W'(inflight_r);
      limit_s   = CR_W'(SKID_DEPTH) + CR_W'(pop_s);
      rd_s      = !rst && (state_r == RUN) && !rewind && lfa_rd_avail && (used_s < limit_s);
      // Landing data is discarded when a rewind has invalidated the read behind it.
      push_s    = inflight_r && (state_r != FLUSH) && !rewind;
      ret_ok_s  = retire && (dlv_cnt_r != {(ADDR_W+1){1'b0}});
      ret_nxt_s = ret_ptr_r + (ADDR_W+1)'(ret_ok_s);
   end

   // Sequencer state, pointers, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         rd_ptr_r   <= {(ADDR_W+1){1'b0}};
         ret_ptr_r  <= {(ADDR_W+1){1'b0}};
         dlv_cnt_r  <= {(ADDR_W+1){1'b0}};
         inflight_r <= 1'b0;
         ack_r      <= 1'b0;
         ack_addr_r <= {ADDR_W{1'b0}};
         err_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE:    state_r <= en ? RUN : IDLE;
            RUN: begin
               if (rewind && inflight_r) begin
                  state_r <= FLUSH;
               end else if (!en) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= RUN;
               end
            end
            FLUSH:   state_r <= en ? RUN : IDLE;
            default: state_r <= IDLE;
         endcase

         inflight_r <= rd_s;
         ret_ptr_r  <= ret_nxt_s;
         ack_r      <= ret_ok_s;
         if (ret_ok_s) begin
            ack_addr_r <= ret_nxt_s[ADDR_W-1:0];
         end
         if (retire && !ret_ok_s) begin
            err_r <= 1'b1;
         end

         // A same-cycle retire is folded in before the rewind resets the read pointer.
         if (rewind) begin
            rd_ptr_r  <= ret_nxt_s;
            dlv_cnt_r <= {(ADDR_W+1){1'b0}};
         end else begin
            rd_ptr_r  <= rd_ptr_r + (ADDR_W+1)'(rd_s);
            dlv_cnt_r <= dlv_cnt_r - (ADDR_W+1)'(ret_ok_s) + (ADDR_W+1)'(pop_s);
         end
      end
   end

   cr_xp10_decomp_fe_lfa_skid #(
      .DATA_W (DATA_W),
      .DEPTH  (SKID_DEPTH),
      .CNT_W  (CNT_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (lfa_rdata),
      .pop       (pop_s),
      .clear     (rewind),
      .occ       (occ_s),
      .head_data (head_s)
   );

   assign lfa_rd          = rd_s;
   assign lfa_raddr       = rd_ptr_r[ADDR_W-1:0];
   assign lfa_rd_ack      = ack_r;
   assign lfa_rd_ack_addr = ack_addr_r;
   assign out_valid       = (occ_s != {CNT_W{1'b0}});
   assign out_data        = head_s;
   assign outstanding     = rd_ptr_r - ret_ptr_r;
   assign retire_err      = err_r;

endmodule
